// File: rtl/threshold_detect_pkg.sv
// ---------------------------------------------------------------------------
// threshold_detect_pkg
//
// Shared definitions for the threshold-detector stage of the switching
// median filter:
//   state_e     - sequencer states (IDLE, RUN, DRAIN)
//   DATA_W_DEF  - default pixel / absolute-difference width
//   ABS_W       - operand width of the generic abs_diff helper
//   abs_diff()  - magnitude of the difference of two unsigned values
// ---------------------------------------------------------------------------
package threshold_detect_pkg;

  localparam int DATA_W_DEF = 8;

  // abs_diff works on a fixed wide operand so one helper serves every
  // DATA_W up to ABS_W; callers zero-extend in and truncate out.
  localparam int ABS_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // The subtraction is one bit wider than the operands so the borrow tells
  // us which operand was larger; the magnitude then always fits back into
  // ABS_W bits and never wraps.
  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                input logic [ABS_W-1:0] b);
    logic [ABS_W:0] diff;
    logic [ABS_W:0] negDiff;
    diff    = {1'b0, a} - {1'b0, b};
    negDiff = ~diff + {{ABS_W{1'b0}}, 1'b1};
    if (diff[ABS_W]) begin
      abs_diff = negDiff[ABS_W-1:0];
    end else begin
      abs_diff = diff[ABS_W-1:0];
    end
  endfunction

endpackage

// File: rtl/abs_diff_stage.sv
// ---------------------------------------------------------------------------
// abs_diff_stage
//
// First pipeline stage of the threshold detector. Registers the accepted
// (CV, MV) pair plus its end-of-frame tag and presents the combinational
// absolute difference |CV - MV| of the registered pair.
//
// Ports:
//   Clk       in   clock, rising edge
//   Reset_n   in   asynchronous active-low reset
//   Flush_i   in   synchronous flush (abort); clears the valid flag
//   Adv_i     in   pipeline advance; stage holds when low
//   Accept_i  in   a new pair is accepted this cycle
//   Last_i    in   the accepted pair is the final one of the frame
//   Cv_i      in   centre value
//   Mv_i      in   median value
//   Valid_o   out  stage holds a valid pair
//   Last_o    out  registered end-of-frame tag
//   Cv_o      out  registered centre value
//   Mv_o      out  registered median value
//   Ad_o      out  |Cv_o - Mv_o|, range 0..2^DATA_W-1
//
// DATA_W must not exceed threshold_detect_pkg::ABS_W.
// ---------------------------------------------------------------------------
module abs_diff_stage
  import threshold_detect_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Flush_i,
  input  logic              Adv_i,
  input  logic              Accept_i,
  input  logic              Last_i,
  input  logic [DATA_W-1:0] Cv_i,
  input  logic [DATA_W-1:0] Mv_i,
  output logic              Valid_o,
  output logic              Last_o,
  output logic [DATA_W-1:0] Cv_o,
  output logic [DATA_W-1:0] Mv_o,
  output logic [DATA_W-1:0] Ad_o
);

  logic              s1Valid_q, s1Valid_d;
  logic              s1Last_q,  s1Last_d;
  logic [DATA_W-1:0] s1Cv_q,    s1Cv_d;
  logic [DATA_W-1:0] s1Mv_q,    s1Mv_d;

  // Next-state for the stage-1 register. When the pipeline cannot advance
  // everything holds so a stalled pair is neither dropped nor duplicated.
  // Data is only loaded on a real accept so idle cycles do not toggle it.
  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Last_d  = s1Last_q;
    s1Cv_d    = s1Cv_q;
    s1Mv_d    = s1Mv_q;
    if (Flush_i) begin
      s1Valid_d = 1'b0;
    end else if (Adv_i) begin
      s1Valid_d = Accept_i;
      if (Accept_i) begin
        s1Last_d = Last_i;
        s1Cv_d   = Cv_i;
        s1Mv_d   = Mv_i;
      end
    end
  end

  // Stage-1 register with asynchronous clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1Valid_q <= 1'b0;
      s1Last_q  <= 1'b0;
      s1Cv_q    <= '0;
      s1Mv_q    <= '0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Last_q  <= s1Last_d;
      s1Cv_q    <= s1Cv_d;
      s1Mv_q    <= s1Mv_d;
    end
  end

  assign Valid_o = s1Valid_q;
  assign Last_o  = s1Last_q;
  assign Cv_o    = s1Cv_q;
  assign Mv_o    = s1Mv_q;
  assign Ad_o    = DATA_W'(abs_diff(ABS_W'(s1Cv_q), ABS_W'(s1Mv_q)));

endmodule

// File: rtl/threshold_detect_ctrl.sv
// ---------------------------------------------------------------------------
// threshold_detect_ctrl
//
// Sequencer for the threshold-detector stage of the switching median
// filter. Each frame streams FRAME_PIXELS (CV, MV) pairs through a two-stage
// pipeline: stage 1 (abs_diff_stage) registers the pair and forms |CV-MV|,
// stage 2 registers the noise decision (|CV-MV| > threshold) and the
// switched pixel (MV when noisy, CV otherwise).
//
// Ports:
//   Clk          in   clock, rising edge
//   Reset_n      in   asynchronous active-low reset
//   Start        in   begins a frame; honoured only in IDLE
//   Abort        in   flushes the pipeline and returns to IDLE
//   Thresh       in   noise threshold, latched on an accepted Start
//   In_Valid     in   CV/MV pair valid
//   In_Ready     out  pair accepted when In_Valid & In_Ready
//   CV, MV       in   centre and median values
//   Out_Valid    out  output pixel valid
//   Out_Ready    in   downstream ready
//   Out_Pixel    out  switched pixel
//   Out_Noisy    out  pixel classed as impulse noise
//   Out_Last     out  frame's final pixel
//   Busy         out  sequencer not idle
//   Done         out  one-cycle pulse after the last pixel handshakes out
//   Noise_Count  out  (NOISE_COUNT_EN only) noisy pixels handshaked this frame
//
// Build option: define NOISE_COUNT_EN to add the Noise_Count output.
// ---------------------------------------------------------------------------
module threshold_detect_ctrl
  import threshold_detect_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int FRAME_PIXELS = 4096
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Abort,
  input  logic [DATA_W-1:0] Thresh,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] CV,
  input  logic [DATA_W-1:0] MV,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Out_Pixel,
  output logic              Out_Noisy,
  output logic              Out_Last,
  output logic              Busy,
  output logic              Done
`ifdef NOISE_COUNT_EN
  ,
  output logic [$clog2(FRAME_PIXELS):0] Noise_Count
`endif
);

  localparam int              CNT_W    = $clog2(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

  state_e            state_q,  state_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [DATA_W-1:0] thresh_q, thresh_d;
  logic              done_q,   done_d;

  logic              s2Valid_q, s2Valid_d;
  logic              s2Noisy_q, s2Noisy_d;
  logic              s2Last_q,  s2Last_d;
  logic [DATA_W-1:0] s2Pixel_q, s2Pixel_d;

  logic              adv;
  logic              inReady;
  logic              accept;
  logic              acceptLast;
  logic              outFire;
  logic              startOk;
  logic              isNoisy;

  logic              s1Valid;
  logic              s1Last;
  logic [DATA_W-1:0] s1Cv;
  logic [DATA_W-1:0] s1Mv;
  logic [DATA_W-1:0] s1Ad;

  // The whole pipeline moves in lock-step: it advances whenever the output
  // register is empty or being drained this cycle.
  assign adv        = ~s2Valid_q | Out_Ready;
  assign inReady    = (state_q == RUN) & adv;
  assign accept     = In_Valid & inReady;
  assign acceptLast = accept & (count_q == LAST_IDX);
  assign outFire    = s2Valid_q & Out_Ready;
  assign startOk    = Start & (state_q == IDLE) & ~Abort;

  abs_diff_stage #(
    .DATA_W (DATA_W)
  ) u_absDiff (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Flush_i  (Abort),
    .Adv_i    (adv),
    .Accept_i (accept),
    .Last_i   (acceptLast),
    .Cv_i     (CV),
    .Mv_i     (MV),
    .Valid_o  (s1Valid),
    .Last_o   (s1Last),
    .Cv_o     (s1Cv),
    .Mv_o     (s1Mv),
    .Ad_o     (s1Ad)
  );

  // Strict comparison: a difference equal to the threshold is still clean.
  assign isNoisy = (s1Ad > thresh_q);

  // Sequencer next-state. Abort overrides every other transition. In DRAIN
  // the handshake of the tagged last pixel raises Done for the following
  // cycle; the state leaves DRAIN only after that pulse, so a Start that
  // coincides with Done is still seen outside IDLE and ignored. The pixel
  // count saturates at the last index rather than wrapping.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    thresh_d = thresh_q;
    done_d   = 1'b0;
    if (Abort) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            state_d  = RUN;
            thresh_d = Thresh;
            count_d  = '0;
          end
        end
        RUN: begin
          if (acceptLast) begin
            state_d = DRAIN;
          end else if (accept) begin
            count_d = count_q + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (done_q) begin
            state_d = IDLE;
          end else if (outFire && s2Last_q) begin
            done_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Sequencer registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      thresh_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      thresh_q <= thresh_d;
      done_q   <= done_d;
    end
  end

  // Stage-2 next-state: noise decision and switched pixel. Holding while
  // stalled keeps the Out_* values stable until the downstream accepts.
  always_comb begin
    s2Valid_d = s2Valid_q;
    s2Noisy_d = s2Noisy_q;
    s2Last_d  = s2Last_q;
    s2Pixel_d = s2Pixel_q;
    if (Abort) begin
      s2Valid_d = 1'b0;
    end else if (adv) begin
      s2Valid_d = s1Valid;
      if (s1Valid) begin
        s2Noisy_d = isNoisy;
        s2Last_d  = s1Last;
        s2Pixel_d = isNoisy ? s1Mv : s1Cv;
      end
    end
  end

  // Stage-2 registers, which directly drive the output interface.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2Valid_q <= 1'b0;
      s2Noisy_q <= 1'b0;
      s2Last_q  <= 1'b0;
      s2Pixel_q <= '0;
    end else begin
      s2Valid_q <= s2Valid_d;
      s2Noisy_q <= s2Noisy_d;
      s2Last_q  <= s2Last_d;
      s2Pixel_q <= s2Pixel_d;
    end
  end

`ifdef NOISE_COUNT_EN
  logic [CNT_W:0] noiseCount_q, noiseCount_d;

  // Counts noisy pixels that actually leave the block. The counter is one
  // bit wider than the pixel index so a fully noisy frame still fits, and
  // it holds its value after Done until the next frame starts.
  always_comb begin
    noiseCount_d = noiseCount_q;
    if (Abort || startOk) begin
      noiseCount_d = '0;
    end else if (outFire && s2Noisy_q) begin
      noiseCount_d = noiseCount_q + {{CNT_W{1'b0}}, 1'b1};
    end
  end

  // Noise counter register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      noiseCount_q <= '0;
    end else begin
      noiseCount_q <= noiseCount_d;
    end
  end

  assign Noise_Count = noiseCount_q;
`else
  // Without the counter, an accepted Start only affects the sequencer.
  logic unusedStartOk;
  assign unusedStartOk = startOk;
`endif

  assign In_Ready  = inReady;
  assign Out_Valid = s2Valid_q;
  assign Out_Pixel = s2Pixel_q;
  assign Out_Noisy = s2Noisy_q;
  assign Out_Last  = s2Last_q;
  assign Busy      = (state_q != IDLE);
  assign Done      = done_q;

endmodule
